lvds_panel_sequencer: RTL

- Power/enable sequencer for the dual-channel LVDS panel path: panel VDD, LVDS link run (timing generator plus gearbox reset release), video unblank and backlight enable with PWM dimming.
- Enforces panel power-on/off timing and changes video state only on frame boundaries.
- Runs in the pixel clock domain (i_clk_div_3_5 rate, ~51.43 MHz). Sits between top-level control and the LVDS transmitter.

---
 rtl/lvds_pkg.sv | 50 +++++
 rtl/lvds_panel_sequencer_bl_pwm.sv | 41 ++++
 rtl/lvds_panel_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/lvds_pkg.sv
// Shared definitions for the LVDS panel path: sequencer state codes, default timing, clock-slot pattern.
// Latency: n/a (package only).
// Backpressure: n/a.
package lvds_pkg;

    typedef enum logic [3:0] {
        ST_OFF     = 4'd0,
        ST_VDD     = 4'd1,
        ST_LINK    = 4'd2,
        ST_VIDEO   = 4'd3,
        ST_RUN     = 4'd4,
        ST_BL_DN   = 4'd5,
        ST_VID_DN  = 4'd6,
        ST_LINK_DN = 4'd7,
        ST_COOL    = 4'd8
    } seq_state_t;

    // Default timing at the 51.43 MHz pixel clock
    localparam int DEF_CNT_W         = 26;
    localparam int DEF_T_VDD         = 1028571;
    localparam int DEF_N_LINK_FRAMES = 3;
    localparam int DEF_T_BL_ON       = 10285714;
    localparam int DEF_T_BL_OFF      = 10285714;
    localparam int DEF_T_LINK_OFF    = 1028571;
    localparam int DEF_T_OFF_MIN     = 25714286;
    localparam int DEF_FRAME_TIMEOUT = 2097152;
    localparam int DEF_PWM_DIV       = 8;

    localparam logic [6:0] LVDS_CLK_SLOT = 7'b1100011;

    typedef struct packed {
        logic vdd_en;
        logic lvds_run;
        logic video_en;
        logic bl_en;
        logic ready;
    } seq_out_t;

    function automatic seq_out_t state_outs(seq_state_t s);
        seq_out_t o;
        o          = '0;
        o.vdd_en   = s inside {ST_VDD, ST_LINK, ST_VIDEO, ST_RUN, ST_BL_DN, ST_VID_DN, ST_LINK_DN};
        o.lvds_run = s inside {ST_LINK, ST_VIDEO, ST_RUN, ST_BL_DN, ST_VID_DN, ST_LINK_DN};
        o.video_en = s inside {ST_VIDEO, ST_RUN, ST_BL_DN, ST_VID_DN};
        o.bl_en    = (s == ST_RUN);
        o.ready    = (s == ST_RUN);
        return o;
    endfunction

endpackage

// File: rtl/lvds_panel_sequencer_bl_pwm.sv
// Backlight PWM: prescaled free-running 8-bit counter, level latched at wrap, compare output.
// Latency: output registered one cycle after the counter/enable it reflects.
// Backpressure: none; runs continuously, output forced low while disabled.
module bl_pwm #(
    parameter int PWM_DIV = 8
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_bl_en,
    input  logic [7:0] i_bl_level,
    output logic       o_bl_pwm
);

    localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    logic [PRE_W-1:0] pre_q;
    logic [7:0]       pwm_cnt_q;
    logic [7:0]       level_q;
    logic             tick;

    assign tick = (pre_q == PRE_W'(PWM_DIV - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pre_q     <= '0;
            pwm_cnt_q <= '0;
            level_q   <= '0;
            o_bl_pwm  <= 1'b0;
        end else begin
            pre_q <= tick ? '0 : pre_q + PRE_W'(1);
            if (tick) begin
                pwm_cnt_q <= pwm_cnt_q + 8'd1;
                // Only take a new duty at the period boundary so no period is glitched
                if (pwm_cnt_q == 8'hFF)
                    level_q <= i_bl_level;
            end
            o_bl_pwm <= i_bl_en && (pwm_cnt_q < level_q);
        end
    end

endmodule

// File: rtl/lvds_panel_sequencer.sv
// Panel power/link/video/backlight sequencer with frame-aligned video changes and frame watchdog.
// Latency: outputs registered, valid the cycle the new state is entered.
// Backpressure: none; power-down always runs to completion before a restart.
module lvds_panel_sequencer
    import lvds_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int T_VDD         = DEF_T_VDD,
    parameter int N_LINK_FRAMES = DEF_N_LINK_FRAMES,
    parameter int T_BL_ON       = DEF_T_BL_ON,
    parameter int T_BL_OFF      = DEF_T_BL_OFF,
    parameter int T_LINK_OFF    = DEF_T_LINK_OFF,
    parameter int T_OFF_MIN     = DEF_T_OFF_MIN,
    parameter int FRAME_TIMEOUT = DEF_FRAME_TIMEOUT,
    parameter int PWM_DIV       = DEF_PWM_DIV
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic       i_frame_start,
    input  logic [7:0] i_bl_level,
    output logic       o_vdd_en,
    output logic       o_lvds_run,
    output logic       o_video_en,
    output logic       o_bl_en,
    output logic       o_bl_pwm,
    output logic       o_ready,
    output logic       o_fault,
    output logic [3:0] o_state
);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, dwell_d;
    logic [CNT_W-1:0] wd_cnt_q;
    logic [7:0]       frame_cnt_q;
    logic             fault_q;
    seq_out_t         outs_q, outs_d;

    logic cnt_zero, wd_active, wd_to, frame_evt, last_frame, state_chg;

    assign cnt_zero   = (cnt_q == '0);
    assign wd_active  = (state_q == ST_LINK) || (state_q == ST_VID_DN);
    assign wd_to      = wd_active && (wd_cnt_q == CNT_W'(FRAME_TIMEOUT - 1));
    // A watchdog expiry stands in for the missing frame_start
    assign frame_evt  = wd_active && (i_frame_start || wd_to);
    assign last_frame = (frame_cnt_q == 8'(N_LINK_FRAMES - 1));
    assign state_chg  = (state_d != state_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF:     if (i_enable) state_d = ST_VDD;
            ST_VDD:     if (!i_enable) state_d = ST_COOL;
                        else if (cnt_zero) state_d = ST_LINK;
            ST_LINK:    if (!i_enable) state_d = ST_LINK_DN;
                        else if (frame_evt && last_frame) state_d = ST_VIDEO;
            ST_VIDEO:   if (!i_enable) state_d = ST_VID_DN;
                        else if (cnt_zero) state_d = ST_RUN;
            ST_RUN:     if (!i_enable) state_d = ST_BL_DN;
            ST_BL_DN:   if (cnt_zero) state_d = ST_VID_DN;
            ST_VID_DN:  if (frame_evt) state_d = ST_LINK_DN;
            ST_LINK_DN: if (cnt_zero) state_d = ST_COOL;
            ST_COOL:    if (cnt_zero) state_d = ST_OFF;
            default:    state_d = ST_COOL;
        endcase

        dwell_d = '0;
        case (state_d)
            ST_VDD:     dwell_d = CNT_W'(T_VDD - 1);
            ST_VIDEO:   dwell_d = CNT_W'(T_BL_ON - 1);
            ST_BL_DN:   dwell_d = CNT_W'(T_BL_OFF - 1);
            ST_LINK_DN: dwell_d = CNT_W'(T_LINK_OFF - 1);
            ST_COOL:    dwell_d = CNT_W'(T_OFF_MIN - 1);
            default:    dwell_d = '0;
        endcase

        outs_d = state_outs(state_d);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_OFF;
            cnt_q       <= '0;
            wd_cnt_q    <= '0;
            frame_cnt_q <= '0;
            fault_q     <= 1'b0;
            outs_q      <= '0;
        end else begin
            state_q <= state_d;
            outs_q  <= outs_d;

            if (state_chg)
                cnt_q <= dwell_d;
            else if (!cnt_zero)
                cnt_q <= cnt_q - CNT_W'(1);

            if (state_chg || !wd_active || frame_evt)
                wd_cnt_q <= '0;
            else
                wd_cnt_q <= wd_cnt_q + CNT_W'(1);

            if (state_chg)
                frame_cnt_q <= '0;
            else if (state_q == ST_LINK && frame_evt)
                frame_cnt_q <= frame_cnt_q + 8'd1;

            if (state_q == ST_OFF && state_d == ST_VDD)
                fault_q <= 1'b0;
            else if (wd_to)
                fault_q <= 1'b1;
        end
    end

    bl_pwm #(
        .PWM_DIV (PWM_DIV)
    ) u_bl_pwm (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_bl_en    (outs_d.bl_en),
        .i_bl_level (i_bl_level),
        .o_bl_pwm   (o_bl_pwm)
    );

    assign o_vdd_en   = outs_q.vdd_en;
    assign o_lvds_run = outs_q.lvds_run;
    assign o_video_en = outs_q.video_en;
    assign o_bl_en    = outs_q.bl_en;
    assign o_ready    = outs_q.ready;
    assign o_fault    = fault_q;
    assign o_state    = state_q;

endmodule
